debug_step_control: RTL and testbench

DEBUG_STEP_CONTROL -- requirements
Module: debug_step_control

---
 rtl/debug_step_if.sv | 42 ++++
 rtl/debug_step_control.sv | 129 ++++++++++++
 tb/tb_debug_step_control.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_step_if.sv
`timescale 1ns/1ps
// debug_step_if
// Purpose: groups the host command handshake, the completion report
// handshake, the pipeline halt/step signals and the debug observation
// outputs of debug_step_control into one bundle.
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1. Command: i_cmd_valid/o_cmd_ready. Report: o_done_valid/i_done_ready.
// The sender holds valid and payload stable until that edge.
// Ports (signals):
//   i_cmd_valid, i_cmd[1:0]     host command (00 NOP, 01 STEP, 10 RUN, 11 HALT)
//   o_cmd_ready                 block accepts a command this cycle
//   i_halt_detected             program-end instruction retired
//   o_step                      advance enable to every pipeline stage register
//   o_done_valid, o_done_status completion report (00 step, 01 host stop, 10 halted)
//   i_done_ready                host consumes the report
//   o_step_count[NB-1:0]        saturating count of o_step cycles
//   o_state[1:0]                FSM state (00 IDLE, 01 STEP, 10 RUN, 11 HALTED)
// Modports: slave = the controller, master = host/pipeline side.
interface debug_step_if #(
  parameter int NB = 32
);
  logic          i_cmd_valid;
  logic [1:0]    i_cmd;
  logic          o_cmd_ready;
  logic          i_halt_detected;
  logic          o_step;
  logic          o_done_valid;
  logic [1:0]    o_done_status;
  logic          i_done_ready;
  logic [NB-1:0] o_step_count;
  logic [1:0]    o_state;

  modport slave (
    input  i_cmd_valid, i_cmd, i_halt_detected, i_done_ready,
    output o_cmd_ready, o_step, o_done_valid, o_done_status, o_step_count, o_state
  );

  modport master (
    output i_cmd_valid, i_cmd, i_halt_detected, i_done_ready,
    input  o_cmd_ready, o_step, o_done_valid, o_done_status, o_step_count, o_state
  );
endinterface

// File: rtl/debug_step_control.sv
`timescale 1ns/1ps
// debug_step_control
// Purpose: single-step / run / halt controller for a debug pipeline. Drives
// the global advance enable o_step, reports completion to the host and
// counts advance cycles.
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous active-high reset
//   bus      debug_step_if.slave (command, report, pipeline and debug signals)
module debug_step_control #(
  parameter int NB = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  debug_step_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_STEP   = 2'b01,
    S_RUN    = 2'b10,
    S_HALTED = 2'b11
  } state_e;

  localparam logic [1:0] CMD_STEP = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  localparam logic [1:0] ST_STEP_DONE = 2'b00;
  localparam logic [1:0] ST_HOST_STOP = 2'b01;
  localparam logic [1:0] ST_PROG_HALT = 2'b10;

  localparam logic [NB-1:0] CNT_MAX = '1;
  localparam logic [NB-1:0] CNT_ONE = {{(NB-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic          step_q, step_d;
  logic          done_valid_q, done_valid_d;
  logic [1:0]    done_status_q, done_status_d;
  logic [NB-1:0] count_q, count_d;

  logic cmd_ready;
  logic cmd_accept;

  // No new command while a step is in flight or a report is unconsumed, so a
  // fresh report can never overwrite a pending one.
  assign cmd_ready  = (state_q != S_STEP) && !done_valid_q;
  assign cmd_accept = bus.i_cmd_valid && cmd_ready;

  always_comb begin
    state_d       = state_q;
    done_valid_d  = done_valid_q;
    done_status_d = done_status_q;

    if (done_valid_q && bus.i_done_ready) begin
      done_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // HALT and NOP in IDLE are accepted and dropped.
        if (cmd_accept && bus.i_cmd == CMD_STEP) begin
          state_d = S_STEP;
        end else if (cmd_accept && bus.i_cmd == CMD_RUN) begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        // The single advance cycle ends here unconditionally.
        done_valid_d = 1'b1;
        if (bus.i_halt_detected) begin
          state_d       = S_HALTED;
          done_status_d = ST_PROG_HALT;
        end else begin
          state_d       = S_IDLE;
          done_status_d = ST_STEP_DONE;
        end
      end
      S_RUN: begin
        // Program end beats a host HALT on the same edge.
        if (bus.i_halt_detected) begin
          state_d       = S_HALTED;
          done_valid_d  = 1'b1;
          done_status_d = ST_PROG_HALT;
        end else if (cmd_accept && bus.i_cmd == CMD_HALT) begin
          state_d       = S_IDLE;
          done_valid_d  = 1'b1;
          done_status_d = ST_HOST_STOP;
        end
      end
      S_HALTED: begin
        // Sticky: STEP/RUN only re-announce that the program has ended.
        if (cmd_accept && (bus.i_cmd == CMD_STEP || bus.i_cmd == CMD_RUN)) begin
          done_valid_d  = 1'b1;
          done_status_d = ST_PROG_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // o_step is registered and is high exactly while in STEP or RUN.
    step_d  = (state_d == S_STEP) || (state_d == S_RUN);
    count_d = (step_q && count_q != CNT_MAX) ? count_q + CNT_ONE : count_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      step_q        <= 1'b0;
      done_valid_q  <= 1'b0;
      done_status_q <= ST_STEP_DONE;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      done_valid_q  <= done_valid_d;
      done_status_q <= done_status_d;
      count_q       <= count_d;
    end
  end

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_step        = step_q;
  assign bus.o_done_valid  = done_valid_q;
  assign bus.o_done_status = done_status_q;
  assign bus.o_step_count  = count_q;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_debug_step_control.sv
`timescale 1ns/1ps
module tb_debug_step_control;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  debug_step_if #(.NB(32)) bus ();
  debug_step_if #(.NB(4))  bus4 ();

  // Narrow-counter instance sees exactly the same stimulus.
  assign bus4.i_cmd_valid     = bus.i_cmd_valid;
  assign bus4.i_cmd           = bus.i_cmd;
  assign bus4.i_halt_detected = bus.i_halt_detected;
  assign bus4.i_done_ready    = bus.i_done_ready;

  debug_step_control #(.NB(32)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  debug_step_control #(.NB(4)) dut4 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus4.slave)
  );

  localparam logic [1:0] C_NOP = 2'b00, C_STEP = 2'b01, C_RUN = 2'b10, C_HALT = 2'b11;
  localparam logic [1:0] Q_IDLE = 2'b00, Q_STEP = 2'b01, Q_RUN = 2'b10, Q_HALTED = 2'b11;
  localparam logic [1:0] R_STEP = 2'b00, R_HOST = 2'b01, R_HALT = 2'b10;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_snap(input string tag, input logic [1:0] st, input logic stp,
                            input logic dv, input logic [1:0] status, input logic rdy,
                            input logic [31:0] cnt);
    check({tag, ".state"}, 64'(bus.o_state), 64'(st));
    check({tag, ".step"},  64'(bus.o_step), 64'(stp));
    check({tag, ".dv"},    64'(bus.o_done_valid), 64'(dv));
    check({tag, ".ready"}, 64'(bus.o_cmd_ready), 64'(rdy));
    check({tag, ".count"}, 64'(bus.o_step_count), 64'(cnt));
    if (dv) check({tag, ".status"}, 64'(bus.o_done_status), 64'(status));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [1:0] cmd);
    bus.i_cmd       = cmd;
    bus.i_cmd_valid = 1'b1;
  endtask

  task automatic idle_cmd();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = C_NOP;
  endtask

  // Waits (bounded) for a report, compares it with the oldest expectation,
  // consumes it and checks that it clears on the next cycle.
  task automatic consume_report(input string tag);
    int waited;
    logic [1:0] exp_st;
    waited = 0;
    while (!bus.o_done_valid && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, ".report_seen"}, 64'(bus.o_done_valid), 64'(1));
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s.queue observed=report expected=none", tag);
    end else begin
      exp_st = exp_q.pop_front();
      check({tag, ".report_status"}, 64'(bus.o_done_status), 64'(exp_st));
    end
    bus.i_done_ready = 1'b1;
    tick();
    bus.i_done_ready = 1'b0;
    check({tag, ".report_clear"}, 64'(bus.o_done_valid), 64'(0));
  endtask

  task automatic reset_pulse();
    i_reset = 1'b1;
    #2;
    i_reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    i_reset             = 1'b1;
    bus.i_cmd_valid     = 1'b0;
    bus.i_cmd           = C_NOP;
    bus.i_halt_detected = 1'b0;
    bus.i_done_ready    = 1'b0;

    tick();
    i_reset = 1'b0;
    check_snap("reset", Q_IDLE, 1'b0, 1'b0, R_STEP, 1'b1, 0);
    check("reset.status", 64'(bus.o_done_status), 64'(0));

    // Single step accepted on the first edge after reset release.
    drive_cmd(C_STEP);
    exp_q.push_back(R_STEP);
    tick();
    idle_cmd();
    check_snap("step_active", Q_STEP, 1'b1, 1'b0, R_STEP, 1'b0, 0);
    tick();
    check_snap("step_done", Q_IDLE, 1'b0, 1'b1, R_STEP, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      drive_cmd(C_RUN);  // must not be accepted while report pending
      tick();
      check_snap($sformatf("hold%0d", i), Q_IDLE, 1'b0, 1'b1, R_STEP, 1'b0, 1);
    end
    idle_cmd();
    consume_report("step");

    // RUN for 10 cycles, with ignored STEP/RUN in the middle, then HALT.
    drive_cmd(C_RUN);
    tick();
    idle_cmd();
    check_snap("run_enter", Q_RUN, 1'b1, 1'b0, R_STEP, 1'b1, 1);
    for (int i = 1; i <= 9; i++) begin
      if (i == 4) drive_cmd(C_STEP);
      if (i == 6) drive_cmd(C_RUN);
      tick();
      idle_cmd();
      check_snap($sformatf("run%0d", i), Q_RUN, 1'b1, 1'b0, R_STEP, 1'b1, 32'(1 + i));
    end
    drive_cmd(C_HALT);
    exp_q.push_back(R_HOST);
    tick();
    idle_cmd();
    check_snap("run_halt", Q_IDLE, 1'b0, 1'b1, R_HOST, 1'b0, 11);
    consume_report("run");

    // Program end and host HALT on the same edge: program end wins.
    drive_cmd(C_RUN);
    tick();
    idle_cmd();
    for (int i = 0; i < 3; i++) tick();
    drive_cmd(C_HALT);
    bus.i_halt_detected = 1'b1;
    exp_q.push_back(R_HALT);
    tick();
    idle_cmd();
    bus.i_halt_detected = 1'b0;
    check_snap("halt_prio", Q_HALTED, 1'b0, 1'b1, R_HALT, 1'b0, 15);
    consume_report("halt_prio");

    // HALTED is sticky.
    drive_cmd(C_STEP);
    exp_q.push_back(R_HALT);
    tick();
    idle_cmd();
    check_snap("halted_step", Q_HALTED, 1'b0, 1'b1, R_HALT, 1'b0, 15);
    consume_report("halted_step");
    drive_cmd(C_RUN);
    exp_q.push_back(R_HALT);
    tick();
    idle_cmd();
    check_snap("halted_run", Q_HALTED, 1'b0, 1'b1, R_HALT, 1'b0, 15);
    consume_report("halted_run");
    drive_cmd(C_NOP);
    bus.i_halt_detected = 1'b1;
    tick();
    idle_cmd();
    bus.i_halt_detected = 1'b0;
    check_snap("halted_nop", Q_HALTED, 1'b0, 1'b0, R_HALT, 1'b1, 15);

    // IDLE ignores HALT, NOP and halt_detected.
    reset_pulse();
    check_snap("reset2", Q_IDLE, 1'b0, 1'b0, R_STEP, 1'b1, 0);
    drive_cmd(C_HALT);
    bus.i_halt_detected = 1'b1;
    tick();
    bus.i_halt_detected = 1'b0;
    drive_cmd(C_NOP);
    check_snap("idle_halt", Q_IDLE, 1'b0, 1'b0, R_STEP, 1'b1, 0);
    tick();
    idle_cmd();
    check_snap("idle_nop", Q_IDLE, 1'b0, 1'b0, R_STEP, 1'b1, 0);

    // Program end retired during a single step.
    drive_cmd(C_STEP);
    tick();
    idle_cmd();
    bus.i_halt_detected = 1'b1;
    exp_q.push_back(R_HALT);
    tick();
    bus.i_halt_detected = 1'b0;
    check_snap("step_halt", Q_HALTED, 1'b0, 1'b1, R_HALT, 1'b0, 1);
    consume_report("step_halt");

    // Counter saturation on the 4-bit instance.
    reset_pulse();
    drive_cmd(C_RUN);
    tick();
    idle_cmd();
    for (int i = 0; i < 20; i++) tick();
    check_snap("run20", Q_RUN, 1'b1, 1'b0, R_STEP, 1'b1, 20);
    check("sat4.count", 64'(bus4.o_step_count), 64'(15));

    // Asynchronous reset between edges while running.
    #2;
    i_reset = 1'b1;
    #1;
    check_snap("async_reset", Q_IDLE, 1'b0, 1'b0, R_STEP, 1'b1, 0);
    check("async_reset.count4", 64'(bus4.o_step_count), 64'(0));
    drive_cmd(C_STEP);
    #1;
    i_reset = 1'b0;
    exp_q.push_back(R_STEP);
    tick();
    idle_cmd();
    check_snap("first_cmd", Q_STEP, 1'b1, 1'b0, R_STEP, 1'b0, 0);
    consume_report("first_cmd");
    check_snap("final", Q_IDLE, 1'b0, 1'b0, R_STEP, 1'b1, 1);
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
